// File: rtl/alu.sv
// alu: registered unsigned adder, sum_o = a_i + b_i at nb_bits+1 width (MSB = carry-out).
// The datapath is a structural carry-select adder built from per-bit full-adder cells.
// Optional build macro ALU_INPUT_REG_EN: a_i/b_i are registered first, giving 2-cycle latency.
module alu #(
    parameter int nb_bits  = 32,
    parameter int blk_bits = 8
) (
    input  logic               clock_i,
    input  logic               rst_n,
    input  logic [nb_bits-1:0] a_i,
    input  logic [nb_bits-1:0] b_i,
    output logic [nb_bits:0]   sum_o
);

    localparam int NBLK = (nb_bits + blk_bits - 1) / blk_bits;

    // Operands seen by the adder (raw inputs or their registered copies)
    logic [nb_bits-1:0] op_a;
    logic [nb_bits-1:0] op_b;

`ifdef ALU_INPUT_REG_EN
    logic [nb_bits-1:0] a_d, a_q;
    logic [nb_bits-1:0] b_d, b_q;

    // Next-state for the operand capture registers
    always_comb begin
        a_d = a_i;
        b_d = b_i;
    end

    // Operand capture registers, cleared by reset like the result register
    always_ff @(posedge clock_i or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign op_a = a_q;
    assign op_b = b_q;
`else
    assign op_a = a_i;
    assign op_b = b_i;
`endif

    // Per-bit ripple results for block carry-in 0 (s0/co0) and carry-in 1 (s1/co1)
    logic [nb_bits-1:0] s0, s1, co0, co1;
    logic [nb_bits-1:0] sel_sum;
    // blk_c[k] is the resolved carry into block k; blk_c[NBLK] is the final carry-out
    logic [NBLK:0]      blk_c;

    assign blk_c[0] = 1'b0;

    for (genvar i = 0; i < nb_bits; i++) begin : g_bit
        localparam int K = i / blk_bits;
        localparam int J = i % blk_bits;

        logic ci0, ci1, p;

        if (J == 0) begin : g_head
            // Block 0 has a fixed carry-in of 0, so both chains collapse to the same ripple
            assign ci0 = 1'b0;
            assign ci1 = (K != 0);
        end else begin : g_chain
            assign ci0 = co0[i-1];
            assign ci1 = co1[i-1];
        end

        assign p      = op_a[i] ^ op_b[i];
        assign s0[i]  = p ^ ci0;
        assign co0[i] = (op_a[i] & op_b[i]) | (p & ci0);
        assign s1[i]  = p ^ ci1;
        assign co1[i] = (op_a[i] & op_b[i]) | (p & ci1);

        // Incoming block carry picks which precomputed sum bit is real
        assign sel_sum[i] = blk_c[K] ? s1[i] : s0[i];

        // Last bit of a block (full or trailing partial) resolves that block's carry-out
        if ((J == blk_bits - 1) || (i == nb_bits - 1)) begin : g_tail
            assign blk_c[K+1] = blk_c[K] ? co1[i] : co0[i];
        end
    end

    logic [nb_bits:0] sum_d, sum_q;

    // Assemble the full-width sum with the final block carry as MSB
    always_comb begin
        sum_d = {blk_c[NBLK], sel_sum};
    end

    // Result register; reset clears it immediately
    always_ff @(posedge clock_i or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu across several nb_bits/blk_bits combinations.
module tb_alu;

`ifdef ALU_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [32:0] e32;
        logic [7:0]  e7;
        logic [1:0]  e1;
    } exp_t;

    logic        clock_i = 1'b0;
    logic        rst_n   = 1'b0;
    logic [31:0] a       = '0;
    logic [31:0] b       = '0;

    logic [32:0] s32, s32p;
    logic [7:0]  s7;
    logic [1:0]  s1;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t q[$];

    always #5 clock_i = ~clock_i;

    alu #(.nb_bits(32), .blk_bits(8)) u32 (
        .clock_i(clock_i), .rst_n(rst_n), .a_i(a), .b_i(b), .sum_o(s32));
    alu #(.nb_bits(32), .blk_bits(3)) u32p (
        .clock_i(clock_i), .rst_n(rst_n), .a_i(a), .b_i(b), .sum_o(s32p));
    alu #(.nb_bits(7), .blk_bits(3)) u7 (
        .clock_i(clock_i), .rst_n(rst_n), .a_i(a[6:0]), .b_i(b[6:0]), .sum_o(s7));
    alu #(.nb_bits(1), .blk_bits(1)) u1 (
        .clock_i(clock_i), .rst_n(rst_n), .a_i(a[0]), .b_i(b[0]), .sum_o(s1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t m;
        m.e32 = {1'b0, x} + {1'b0, y};
        m.e7  = {1'b0, x[6:0]} + {1'b0, y[6:0]};
        m.e1  = {1'b0, x[0]} + {1'b0, y[0]};
        return m;
    endfunction

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, "_n32b8"}, 64'(s32),  64'(e.e32));
        chk({tag, "_n32b3"}, 64'(s32p), 64'(e.e32));
        chk({tag, "_n7b3"},  64'(s7),   64'(e.e7));
        chk({tag, "_n1b1"},  64'(s1),   64'(e.e1));
    endtask

    // One cycle: compare the result due now, then drive and record the next operand pair
    task automatic step(input string tag, input logic [31:0] na, input logic [31:0] nb);
        @(negedge clock_i);
        if (q.size() >= LAT) chk_all(tag, q.pop_front());
        a = na;
        b = nb;
        q.push_back(model(na, nb));
    endtask

    // Release reset at a negedge; input registers (if any) restart from zero
    task automatic release_rst();
        rst_n = 1'b1;
        q.delete();
        for (int i = 0; i < LAT - 1; i++) q.push_back('0);
        q.push_back(model(a, b));
    endtask

    initial begin
        a = 32'd5;
        b = 32'd10;
        // Held in reset with nonzero operands
        repeat (2) begin
            @(negedge clock_i);
            chk_all("rst_hold", '0);
        end
        chk_all("pre_release", '0);
        release_rst();

        step("add_5_10",  32'hFFFF_FFFF, 32'h0000_0001);
        step("carry_one", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step("all_ones",  32'h1234_5678, 32'h8765_4321);
        step("no_carry",  32'h0000_0000, 32'h0000_0000);
        step("zero",      $urandom, $urandom);
        for (int i = 0; i < 1000; i++) step("rand", $urandom, $urandom);
        step("drain", 32'h0, 32'h0);

        // Reset asserted mid-cycle must clear the output before the next edge
        @(posedge clock_i);
        a = 32'hDEAD_BEEF;
        b = 32'h1357_9BDF;
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", '0);
        @(negedge clock_i);
        chk_all("async_rst_hold", '0);
        release_rst();
        step("post_rst", 32'hFFFF_FFFF, 32'h0000_0001);
        for (int i = 0; i < 8; i++) step("post_rand", $urandom, $urandom);
        repeat (LAT) step("tail", 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
